// File: rtl/tone_if.sv
// Note-request handshake, frequency-LUT lookup and tone outputs of tone_divider.
// The slave side is the divider; the master side is the requester plus the LUT.
`timescale 1ns/1ps
interface tone_if;
  logic [6:0]  note_in;
  logic        note_valid;
  logic        note_ready;
  logic        note_off;
  logic [6:0]  lut_note;
  logic [27:0] lut_count;
  logic        wave;
  logic        edge_tick;
  logic        active;

  modport master (
    output note_in, note_valid, note_off, lut_count,
    input  note_ready, lut_note, wave, edge_tick, active
  );

  modport slave (
    input  note_in, note_valid, note_off, lut_count,
    output note_ready, lut_note, wave, edge_tick, active
  );
endinterface

// File: rtl/tone_divider.sv
// Square-wave tone generator: looks up a half-period for the requested note and divides clk.
// Optional macro TONE_SYNC_RETUNE_EN defers retunes to the next half-period boundary.
`timescale 1ns/1ps
module tone_divider (
  input  logic   clk,
  input  logic   reset,
  tone_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, RETUNE} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  note_reg, note_next;
  logic [6:0]  prev_note_reg, prev_note_next;
  logic [27:0] period_reg, period_next;
  logic [27:0] count_reg, count_next;
  logic        wave_reg, wave_next;
  logic        tick_reg, tick_next;
  logic        active_reg, active_next;
  logic        ready_reg, ready_next;
  logic        xfer;
  logic        lut_zero;
`ifdef TONE_SYNC_RETUNE_EN
  logic        pend_reg, pend_next;
  logic [27:0] pend_period_reg, pend_period_next;
`endif

  assign xfer     = bus.note_valid && ready_reg;
  assign lut_zero = (bus.lut_count == 28'd0);

  always_comb begin
    state_next     = state_reg;
    note_next      = note_reg;
    prev_note_next = prev_note_reg;
    period_next    = period_reg;
    count_next     = count_reg;
    wave_next      = wave_reg;
    tick_next      = 1'b0;
    active_next    = active_reg;
`ifdef TONE_SYNC_RETUNE_EN
    pend_next        = pend_reg;
    pend_period_next = pend_period_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (xfer) begin
          note_next  = bus.note_in;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (lut_zero) begin
          state_next = IDLE;
        end else begin
          period_next = bus.lut_count;
          count_next  = bus.lut_count;
          wave_next   = 1'b0;
          active_next = 1'b1;
          state_next  = RUN;
        end
      end
      RUN, RETUNE: begin
        // Reload wins over decrement, so the counter can never wrap below zero.
        if (count_reg == 28'd0) begin
          count_next = period_reg;
          wave_next  = ~wave_reg;
          tick_next  = 1'b1;
`ifdef TONE_SYNC_RETUNE_EN
          if (pend_reg) begin
            count_next  = pend_period_reg;
            period_next = pend_period_reg;
            pend_next   = 1'b0;
          end
`endif
        end else begin
          count_next = count_reg - 28'd1;
        end

        if (state_reg == RETUNE) begin
          state_next = RUN;
          if (lut_zero) begin
            note_next = prev_note_reg;
          end else begin
`ifdef TONE_SYNC_RETUNE_EN
            pend_next        = 1'b1;
            pend_period_next = bus.lut_count;
`else
            period_next = bus.lut_count;
            count_next  = bus.lut_count;
            wave_next   = wave_reg;
            tick_next   = 1'b0;
`endif
          end
        end else if (xfer) begin
          prev_note_next = note_reg;
          note_next      = bus.note_in;
          state_next     = RETUNE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request accepted alongside note_off still completes the handshake but is dropped.
    if (bus.note_off) begin
      state_next  = IDLE;
      note_next   = note_reg;
      wave_next   = 1'b0;
      tick_next   = 1'b0;
      active_next = 1'b0;
      count_next  = 28'd0;
`ifdef TONE_SYNC_RETUNE_EN
      pend_next   = 1'b0;
`endif
    end

    case (state_next)
      IDLE:    ready_next = 1'b1;
`ifdef TONE_SYNC_RETUNE_EN
      RUN:     ready_next = ~pend_next;
`else
      RUN:     ready_next = 1'b1;
`endif
      default: ready_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      note_reg      <= 7'd0;
      prev_note_reg <= 7'd0;
      period_reg    <= 28'd0;
      count_reg     <= 28'd0;
      wave_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      active_reg    <= 1'b0;
      ready_reg     <= 1'b1;
`ifdef TONE_SYNC_RETUNE_EN
      pend_reg        <= 1'b0;
      pend_period_reg <= 28'd0;
`endif
    end else begin
      state_reg     <= state_next;
      note_reg      <= note_next;
      prev_note_reg <= prev_note_next;
      period_reg    <= period_next;
      count_reg     <= count_next;
      wave_reg      <= wave_next;
      tick_reg      <= tick_next;
      active_reg    <= active_next;
      ready_reg     <= ready_next;
`ifdef TONE_SYNC_RETUNE_EN
      pend_reg        <= pend_next;
      pend_period_reg <= pend_period_next;
`endif
    end
  end

  assign bus.note_ready = ready_reg;
  assign bus.lut_note   = note_reg;
  assign bus.wave       = wave_reg;
  assign bus.edge_tick  = tick_reg;
  assign bus.active     = active_reg;
endmodule

// File: tb/tb_tone_divider.sv
// Bench for tone_divider: directed scenarios then random traffic, compared every cycle
// against a timestamp-based model of when the tone should toggle.
`timescale 1ns/1ps
module tb_tone_divider;
  logic clk;
  logic reset;
  tone_if bus ();

  tone_divider dut (.clk(clk), .reset(reset), .bus(bus));

  logic [27:0] lut_tb [128];
  assign bus.lut_count = lut_tb[bus.lut_note];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_RETUNE = 3;

  int       pass_cnt = 0;
  int       total_cnt = 0;
  int       cyc = 0;
  int       m_phase = P_IDLE;
  bit [6:0] m_note = 0, m_prev = 0;
  bit       m_wave = 0, m_tick = 0, m_active = 0, m_ready = 1;
  bit       m_pend = 0;
  int       m_half = 0, m_pend_half = 0, m_next = 0;

  // Expected behaviour at one rising edge, in terms of absolute toggle times.
  task automatic model_edge(bit r, bit v, bit [6:0] n, bit off);
    bit xfer;
    bit retune_valid;
    int lut;
    xfer = v && m_ready;
    cyc++;
    if (r) begin
      m_phase = P_IDLE; m_note = 0; m_prev = 0; m_wave = 0; m_tick = 0;
      m_active = 0; m_pend = 0; m_ready = 1;
      return;
    end
    m_tick = 0;
    if (off) begin
      m_phase = P_IDLE; m_wave = 0; m_active = 0; m_pend = 0; m_ready = 1;
      return;
    end
    case (m_phase)
      P_IDLE: if (xfer) begin m_note = n; m_phase = P_LOAD; end
      P_LOAD: begin
        lut = int'(lut_tb[m_note]);
        if (lut == 0) m_phase = P_IDLE;
        else begin
          m_half = lut + 1; m_next = cyc + lut + 1;
          m_wave = 0; m_active = 1; m_phase = P_RUN;
        end
      end
      default: begin
        lut = int'(lut_tb[m_note]);
        retune_valid = (m_phase == P_RETUNE) && (lut != 0);
`ifndef TONE_SYNC_RETUNE_EN
        if (retune_valid) begin
          m_half = lut + 1; m_next = cyc + lut + 1;
        end else
`endif
        if (cyc == m_next) begin
          m_wave = !m_wave; m_tick = 1;
          if (m_pend) begin m_half = m_pend_half; m_pend = 0; end
          m_next = cyc + m_half;
        end
`ifdef TONE_SYNC_RETUNE_EN
        if (retune_valid) begin m_pend = 1; m_pend_half = lut + 1; end
`endif
        if (m_phase == P_RETUNE) begin
          if (!retune_valid) m_note = m_prev;
          m_phase = P_RUN;
        end else if (xfer) begin
          m_prev = m_note; m_note = n; m_phase = P_RETUNE;
        end
      end
    endcase
    m_ready = (m_phase == P_IDLE) || (m_phase == P_RUN && !m_pend);
  endtask

  task automatic check(string tag, logic [27:0] obs, logic [27:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all();
    check("wave",       28'(bus.wave),       28'(m_wave));
    check("edge_tick",  28'(bus.edge_tick),  28'(m_tick));
    check("active",     28'(bus.active),     28'(m_active));
    check("note_ready", 28'(bus.note_ready), 28'(m_ready));
    check("lut_note",   28'(bus.lut_note),   28'(m_note));
  endtask

  task automatic step(bit r, bit v, bit [6:0] n, bit off);
    reset = r; bus.note_valid = v; bus.note_in = n; bus.note_off = off;
    @(posedge clk);
    if (v && m_ready && !r)
      $display("xfer note=%0d off=%0b cyc=%0d", n, off, cyc + 1);
    model_edge(r, v, n, off);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++) step(0, 0, 7'd0, 0);
  endtask

  // Bounded by the largest possible half-period in the table.
  task automatic wait_tick();
    for (int i = 0; i < 40 && !m_tick; i++) step(0, 0, 7'd0, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      lut_tb[i] = ($urandom_range(0, 4) == 0) ? 28'd0 : 28'($urandom_range(1, 9));
    lut_tb[5] = 28'd3; lut_tb[20] = 28'd7; lut_tb[33] = 28'd2; lut_tb[108] = 28'd0;
    reset = 1'b1; bus.note_valid = 1'b0; bus.note_in = 7'd0; bus.note_off = 1'b0;
    @(negedge clk);

    step(1, 0, 7'd0, 0); step(1, 0, 7'd0, 0);
    idle(3);
    // Note 5, half-period 4 cycles
    step(0, 1, 7'd5, 0);
    idle(20);
    // Retune to half-period 8 shortly after a toggle
    wait_tick();
    step(0, 1, 7'd20, 0);
    idle(30);
    // Retune to an out-of-range note keeps the old tone
    wait_tick();
    step(0, 1, 7'd108, 0);
    idle(12);
    // note_off together with a request
    step(0, 1, 7'd33, 1);
    idle(3);
    // Out-of-range note from IDLE
    step(0, 1, 7'd108, 0);
    idle(3);
    // Reset during LOAD
    step(0, 1, 7'd5, 0);
    step(1, 0, 7'd0, 0);
    idle(2);
    // Reset during RETUNE
    step(0, 1, 7'd5, 0); idle(6);
    step(0, 1, 7'd20, 0);
    step(1, 0, 7'd0, 0);
    idle(2);
    // Reset just after the retune sample (pending when deferred)
    step(0, 1, 7'd5, 0); idle(6);
    step(0, 1, 7'd20, 0);
    idle(1);
    step(1, 0, 7'd0, 0);
    idle(2);

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           7'($urandom_range(0, 127)), $urandom_range(0, 39) == 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
